// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the parametrised UART transmitter.
package uart_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   localparam int OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous holding FIFO with a first-word-fall-through read port.
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem[rd_ptr];

   // NOTE: storage carries no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_frame_transmitter.sv
// UART transmitter: 5..9 data bits, optional parity, 1/2 stop bits, 16x clock.
// Parity generation is built only when UART_TX_PARITY_EN is defined.
module uart_frame_transmitter
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY     = PARITY_NONE,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk_baud_16x,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] trans_data,
   input  logic                 trans_write,
   output logic                 trans_busy,
   output logic                 trans_idle,
   output logic                 tx
);

   localparam int IDX_W = $clog2(DATA_BITS);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [3:0]       PHASE_LAST = 4'(OVERSAMPLE - 1);
   localparam logic [IDX_W-1:0] DATA_LAST  = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] STOP_LAST  = IDX_W'(STOP_BITS - 1);

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_frame_transmitter: DATA_BITS must be 5..9");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_frame_transmitter: STOP_BITS must be 1 or 2");
   end
   if (PARITY != PARITY_NONE && PARITY != PARITY_EVEN && PARITY != PARITY_ODD) begin : g_bad_parity
      $error("uart_frame_transmitter: PARITY must be NONE, EVEN or ODD");
   end
   if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_frame_transmitter: FIFO_DEPTH must be a power of two in 2..16");
   end

   tx_state_t           state;
   logic [3:0]          phase;
   logic [IDX_W-1:0]    bit_idx;
   logic [DATA_BITS-1:0] shift;
   logic [DATA_BITS-1:0] fifo_rdata;
   logic                fifo_full;
   logic                fifo_empty;
   logic [CNT_W-1:0]    fifo_count;
   logic                push;
   logic                pop;
   logic                phase_end;
   logic                stop_end;
`ifdef UART_TX_PARITY_EN
   logic                parity_bit;
`endif

   assign push      = trans_write && !trans_busy && !fifo_full;
   assign phase_end = (phase == PHASE_LAST);
   assign stop_end  = (state == ST_STOP) && phase_end && (bit_idx == STOP_LAST);
   assign pop       = !fifo_empty && ((state == ST_IDLE) || stop_end);

   uart_tx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk_baud_16x),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .wdata (trans_data),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk_baud_16x) begin
      if (reset) begin
         state      <= ST_IDLE;
         phase      <= '0;
         bit_idx    <= '0;
         shift      <= '0;
         tx         <= 1'b1;
         trans_busy <= 1'b0;
         trans_idle <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_bit <= 1'b0;
`endif
      end else begin
         // NOTE: busy ignores a same-cycle pop, so a full FIFO rejects that write.
         trans_busy <= (fifo_count + CNT_W'(push)) == CNT_W'(FIFO_DEPTH);
         trans_idle <= fifo_empty && ((state == ST_IDLE) || stop_end);

         case (state)
            ST_IDLE: begin
               tx <= 1'b1;
            end
            ST_START: begin
               tx    <= 1'b0;
               phase <= phase + 4'd1;
               if (phase_end) begin
                  state   <= ST_DATA;
                  bit_idx <= '0;
               end
            end
            ST_DATA: begin
               tx    <= shift[0];
               phase <= phase + 4'd1;
               if (phase_end) begin
                  shift <= shift >> 1;
                  if (bit_idx == DATA_LAST) begin
                     bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                     state   <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
`else
                     state   <= ST_STOP;
`endif
                  end else begin
                     bit_idx <= bit_idx + IDX_W'(1);
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               tx    <= parity_bit;
               phase <= phase + 4'd1;
               if (phase_end) begin
                  state   <= ST_STOP;
                  bit_idx <= '0;
               end
            end
`endif
            ST_STOP: begin
               tx    <= 1'b1;
               phase <= phase + 4'd1;
               if (stop_end) begin
                  state <= ST_IDLE;
               end else if (phase_end) begin
                  bit_idx <= bit_idx + IDX_W'(1);
               end
            end
            default: begin
               tx    <= 1'b1;
               state <= ST_IDLE;
            end
         endcase

         // A pop (from IDLE or at the end of the last stop bit) overrides the
         // state chosen above and starts the next frame with no idle bit.
         if (pop) begin
            shift   <= fifo_rdata;
            state   <= ST_START;
            phase   <= '0;
            bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= (^fifo_rdata) ^ (PARITY == PARITY_ODD);
`endif
         end
      end
   end

endmodule

// File: tb/tb_uart_frame_transmitter.sv
// Self-checking bench: four transmitter configurations against a frame-level model.
module tb_uart_frame_transmitter;
   import uart_pkg::*;

   localparam int N = 4;

   logic         clk;
   logic [N-1:0] rst;
   logic [N-1:0] wr;
   logic [8:0]   din [N];
   wire  [N-1:0] busy;
   wire  [N-1:0] idle;
   wire  [N-1:0] txl;

   int errors = 0;
   int checks = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   uart_frame_transmitter #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(PARITY_NONE), .FIFO_DEPTH(4)) dut_a (
      .clk_baud_16x(clk), .reset(rst[0]), .trans_data(din[0][7:0]), .trans_write(wr[0]),
      .trans_busy(busy[0]), .trans_idle(idle[0]), .tx(txl[0]));
   uart_frame_transmitter #(.DATA_BITS(5), .STOP_BITS(2), .PARITY(PARITY_NONE), .FIFO_DEPTH(4)) dut_b (
      .clk_baud_16x(clk), .reset(rst[1]), .trans_data(din[1][4:0]), .trans_write(wr[1]),
      .trans_busy(busy[1]), .trans_idle(idle[1]), .tx(txl[1]));
   uart_frame_transmitter #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(PARITY_EVEN), .FIFO_DEPTH(2)) dut_c (
      .clk_baud_16x(clk), .reset(rst[2]), .trans_data(din[2][7:0]), .trans_write(wr[2]),
      .trans_busy(busy[2]), .trans_idle(idle[2]), .tx(txl[2]));
   uart_frame_transmitter #(.DATA_BITS(8), .STOP_BITS(1), .PARITY(PARITY_ODD), .FIFO_DEPTH(2)) dut_d (
      .clk_baud_16x(clk), .reset(rst[3]), .trans_data(din[3][7:0]), .trans_write(wr[3]),
      .trans_busy(busy[3]), .trans_idle(idle[3]), .tx(txl[3]));

   // Per-instance configuration, mirroring the instance parameters above.
   function automatic int db(input int i);
      return (i == 1) ? 5 : 8;
   endfunction
   function automatic int sb(input int i);
      return (i == 1) ? 2 : 1;
   endfunction
   function automatic int dp(input int i);
      return (i >= 2) ? 2 : 4;
   endfunction
   function automatic int pm(input int i);
      return (i == 2) ? PARITY_EVEN : (i == 3) ? PARITY_ODD : PARITY_NONE;
   endfunction
   function automatic int par_on(input int i);
`ifdef UART_TX_PARITY_EN
      return (pm(i) != PARITY_NONE) ? 1 : 0;
`else
      return 0;
`endif
   endfunction
   function automatic int flen(input int i);
      return OVERSAMPLE * (1 + db(i) + par_on(i) + sb(i));
   endfunction

   // Line value of bit k of a frame carrying word w.
   function automatic bit fbit(input int i, input int w, input int k);
      int ones;
      if (k == 0) return 1'b0;
      if (k <= db(i)) return bit'((w >> (k - 1)) & 1);
      if (par_on(i) == 1 && k == db(i) + 1) begin
         ones = $countones(w);
         return (pm(i) == PARITY_EVEN) ? bit'(ones & 1) : bit'(~ones & 1);
      end
      return 1'b1;
   endfunction

   // Frame-level model: queue of words, current frame word and clock position.
   int mq    [N][16];
   int mhead [N];
   int mcnt  [N];
   int mword [N];
   int mpos  [N];
   bit mact  [N];
   bit mbusy [N];
   bit midle [N];
   bit mtx   [N];
   bit mvalid[N];

   task automatic model_step(input int i);
      int  pre_cnt;
      bit  pre_act;
      int  pre_pos;
      bit  acc;
      bit  do_pop;
      if (rst[i]) begin
         mhead[i] = 0; mcnt[i] = 0; mact[i] = 0; mpos[i] = 0;
         mbusy[i] = 0; midle[i] = 1; mtx[i] = 1; mvalid[i] = 1;
         return;
      end
      pre_cnt = mcnt[i];
      pre_act = mact[i];
      pre_pos = mpos[i];
      mtx[i] = pre_act ? fbit(i, mword[i], pre_pos / OVERSAMPLE) : 1'b1;
      acc    = wr[i] && !mbusy[i];
      do_pop = (pre_cnt > 0) && (!pre_act || pre_pos == flen(i) - 1);
      if (pre_act) begin
         mpos[i] = pre_pos + 1;
         if (mpos[i] == flen(i)) mact[i] = 0;
      end
      if (do_pop) begin
         mword[i] = mq[i][mhead[i]];
         mhead[i] = (mhead[i] + 1) % 16;
         mcnt[i]  = mcnt[i] - 1;
         mact[i]  = 1;
         mpos[i]  = 0;
      end
      if (acc) begin
         mq[i][(mhead[i] + mcnt[i]) % 16] = int'(din[i]) & ((1 << db(i)) - 1);
         mcnt[i] = mcnt[i] + 1;
      end
      mbusy[i] = (pre_cnt + int'(acc)) == dp(i);
      midle[i] = (pre_cnt == 0) && !mact[i];
   endtask

   initial for (int i = 0; i < N; i++) mvalid[i] = 0;

   always @(posedge clk) begin
      for (int i = 0; i < N; i++) model_step(i);
   end

   task automatic check(input string name, input int inst, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s[%0d] got=%0h expected=%0h at %0t", name, inst, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (mvalid[i]) begin
            check("tx", i, int'(txl[i]), int'(mtx[i]));
            check("trans_busy", i, int'(busy[i]), int'(mbusy[i]));
            check("trans_idle", i, int'(idle[i]), int'(midle[i]));
         end
      end
   end

   // Write one word, then sample the middle of each bit for nb bits.
   task automatic run_frame(input int i, input int d, input int nb,
                            output int cap, output int low, output int fall);
      cap = 0; low = 0; fall = -1;
      wr[i] = 1'b1; din[i] = 9'(d);
      @(negedge clk);
      wr[i] = 1'b0;
      for (int n = 1; n <= 200; n++) begin
         @(negedge clk);
         if (!idle[i]) low++;
         if (!txl[i] && fall < 0) fall = n;
         if (n >= 10 && (n - 2) % 16 == 8 && (n - 2) / 16 < nb)
            cap |= int'(txl[i]) << ((n - 2) / 16);
      end
   endtask

   initial begin
      int cap, low, fall, acc, txlow;
      rst = '1; wr = '0;
      for (int i = 0; i < N; i++) din[i] = '0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < N; i++) begin
         check("reset_tx", i, int'(txl[i]), 1);
         check("reset_busy", i, int'(busy[i]), 0);
         check("reset_idle", i, int'(idle[i]), 1);
      end
      rst = '0;
      repeat (2) @(negedge clk);

      // 8N1, 0x42
      run_frame(0, 'h42, 10, cap, low, fall);
      check("frame_42_bits", 0, cap, 'h284);
      check("frame_42_idle_low", 0, low, 160);
      check("frame_42_tx_fall", 0, fall, 2);

      // 5 data bits, 2 stop bits, 0x15
      run_frame(1, 'h15, 8, cap, low, fall);
      check("frame_15_bits", 1, cap, 'hEA);
      check("frame_15_idle_low", 1, low, 128);

      // Parity configurations, 0xCA
`ifdef UART_TX_PARITY_EN
      run_frame(2, 'hCA, 11, cap, low, fall);
      check("frame_even_bits", 2, cap, 'h594);
      check("frame_even_idle_low", 2, low, 176);
      run_frame(3, 'hCA, 11, cap, low, fall);
      check("frame_odd_bits", 3, cap, 'h794);
      check("frame_odd_idle_low", 3, low, 176);
`else
      run_frame(2, 'hCA, 10, cap, low, fall);
      check("frame_even_bits", 2, cap, 'h394);
      check("frame_even_idle_low", 2, low, 160);
      run_frame(3, 'hCA, 10, cap, low, fall);
      check("frame_odd_bits", 3, cap, 'h394);
      check("frame_odd_idle_low", 3, low, 160);
`endif

      // Hold write high with 0x01..0x08: five words accepted, frames back-to-back
      acc = 0; low = 0;
      for (int k = 1; k <= 8; k++) begin
         wr[0] = 1'b1; din[0] = 9'(k);
         if (!busy[0]) acc++;
         @(negedge clk);
         if (!idle[0]) low++;
      end
      wr[0] = 1'b0;
      check("burst_accepted", 0, acc, 5);
      check("burst_busy", 0, int'(busy[0]), 1);
      for (int n = 0; n < 820; n++) begin
         @(negedge clk);
         if (!idle[0]) low++;
      end
      check("burst_idle_low", 0, low, 800);

      // Write on the edge that ends the last stop bit
      wr[0] = 1'b1; din[0] = 9'h3C;
      @(negedge clk);
      wr[0] = 1'b0;
      repeat (160) @(negedge clk);
      wr[0] = 1'b1; din[0] = 9'h81;
      @(negedge clk);
      wr[0] = 1'b0;
      check("stop_edge_idle", 0, int'(idle[0]), 1);
      check("stop_edge_tx", 0, int'(txl[0]), 1);
      @(negedge clk);
      check("gap_tx", 0, int'(txl[0]), 1);
      check("gap_idle", 0, int'(idle[0]), 0);
      @(negedge clk);
      check("restart_tx", 0, int'(txl[0]), 0);
      repeat (200) @(negedge clk);

      // Reset in the middle of DATA with a second word queued
      wr[0] = 1'b1; din[0] = 9'h5A;
      @(negedge clk);
      din[0] = 9'h33;
      @(negedge clk);
      wr[0] = 1'b0;
      repeat (60) @(negedge clk);
      rst[0] = 1'b1;
      @(negedge clk);
      rst[0] = 1'b0;
      check("mid_reset_tx", 0, int'(txl[0]), 1);
      check("mid_reset_idle", 0, int'(idle[0]), 1);
      check("mid_reset_busy", 0, int'(busy[0]), 0);
      txlow = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (!txl[0]) txlow++;
      end
      check("no_retransmit", 0, txlow, 0);
      run_frame(0, 'hA5, 10, cap, low, fall);
      check("post_reset_bits", 0, cap, 'h34A);

      // Randomised writes on all instances
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            wr[i]  = ($urandom_range(0, 3) == 0);
            din[i] = 9'($urandom);
         end
         @(negedge clk);
      end
      wr = '0;
      repeat (1200) @(negedge clk);
      for (int i = 0; i < N; i++) check("drained_idle", i, int'(idle[i]), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_frame_transmitter.md
# uart_frame_transmitter

Parametrised UART transmitter, successor to the fixed 8N1 transmitter. Serialises words of 5–9 data bits with optional parity and 1 or 2 stop bits, clocked at 16× the baud rate. A small holding FIFO decouples the producer from the serialiser, so back-to-back frames go out with no idle gap. Sits between a bus-side register interface and the `tx` pad.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal range 5..9.
- `STOP_BITS`, default 1: stop bits per frame, 1 or 2.
- `PARITY`, default `PARITY_NONE`: one of `PARITY_NONE`, `PARITY_EVEN`, `PARITY_ODD` (package constants). Honoured only with `UART_TX_PARITY_EN`.
- `FIFO_DEPTH`, default 4: holding FIFO entries; power of two, 2..16.

Ports:
- `clk_baud_16x`  in  1  Sole clock, 16× baud.
- `reset`  in  1  Synchronous, active-high.
- `trans_data`  in  DATA_BITS  Word to send. Sent LSB first.
- `trans_write`  in  1  Write strobe. Sampled on every rising edge.
- `trans_busy`  out  1  FIFO full. Writes are ignored while high.
- `trans_idle`  out  1  FIFO empty and serialiser in IDLE.
- `tx`  out  1  Serial line. Idle high.

## Operation
- A write is accepted on an edge where `trans_write`=1 and `trans_busy`=0. The word is pushed into the FIFO. Holding `trans_write` high enqueues one word per cycle until the FIFO is full.
- Serialiser FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE or START.
  - IDLE: pops the FIFO head when the FIFO is not empty.
  - START: drives 0.
  - DATA: drives `DATA_BITS` bits, LSB first.
  - PARITY: drives the XOR of the data bits for EVEN, or its inverse for ODD. This state exists only when enabled and `PARITY`≠NONE.
  - STOP: drives 1 for `STOP_BITS` bit periods.
- At the end of STOP, if the FIFO is non-empty, the FSM pops the next word and enters START directly, with zero idle bits between frames.
- Every bit is held for exactly 16 clocks. A 4-bit phase counter and a bit index (width ⌈log2(DATA_BITS)⌉) track position within the frame.
- FIFO full with a pop in the same cycle: `trans_busy` is registered from the pre-pop count, so that write is still rejected.
- FIFO empty with a write in the same cycle: the word is not popped until the following edge (no bypass path).
- Reset mid-frame:
  - `tx` returns to 1 on the reset edge.
  - The FIFO is flushed and the frame is abandoned; no partial retransmission.
- Illegal parameter values stop elaboration with `$error`.

## Timing
- Reset values: `tx`=1, `trans_busy`=0, `trans_idle`=1. All outputs are registered.
- Latency from an idle system:
  - Write accepted at edge E.
  - Word popped at E+1.
  - `tx` falls after edge E+2.
  - `trans_idle` falls after edge E+1.
- Frame length = 16·(1 + DATA_BITS + P + STOP_BITS) clocks, where P is 1 when parity is active and 0 otherwise.
- `trans_idle` rises on the edge that ends the last stop bit, provided the FIFO is empty.
- `trans_busy` rises on the edge that makes the count equal `FIFO_DEPTH`. It falls on the edge after the pop that frees a slot.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state and parity generator are built, and `PARITY` is honoured.
- Not defined: no parity logic is built. `PARITY` is ignored and frames are always `DATA_BITS`-N-`STOP_BITS`.

## Structure
- Package `uart_pkg` holds:
  - parity constants `PARITY_NONE`/`PARITY_EVEN`/`PARITY_ODD`;
  - the FSM state encoding;
  - `OVERSAMPLE`=16.
- Sub-module `uart_tx_fifo`: synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty, and a first-word-fall-through read port.
- The top level holds the FSM, counters, shift register and parity.

## Test plan
- Default 8N1: write 0x42 once → `tx` carries 0,0,1,0,0,0,0,1,0,1, each bit 16 clocks. `tx` falls 2 edges after acceptance. `trans_idle` returns after 160 clocks of frame.
- `UART_TX_PARITY_EN`, PARITY_EVEN: send 0xCA → parity bit 0. PARITY_ODD: send 0xCA → parity bit 1. Frame is 176 clocks.
- `DATA_BITS`=5, `STOP_BITS`=2: send 0x15 → 0,1,0,1,0,1,1,1, total 128 clocks.
- Hold `trans_write` high with `FIFO_DEPTH`=4 and data 0x01..0x08 → words 0x01–0x05 accepted (the first pops immediately), then `trans_busy`=1. Five frames go out back-to-back with no idle bit.
- Assert `reset` for 1 cycle in the middle of DATA → `tx`=1 on that edge, FIFO empty, `trans_idle`=1. A new write afterwards produces a clean frame.
- Write on the same edge that the final stop bit ends → next START begins only after a pop, with exactly 1 idle-high clock.
